// File: rtl/arm7_pkg.sv
// Shared constants and state encoding for the LDM/STM block-transfer sequencer.
package arm7_pkg;
    localparam logic [3:0] REG_PC     = 4'd15;
    localparam int         WORD_BYTES = 4;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CALC = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_MEM  = 3'd4;
    localparam logic [2:0] S_WR   = 3'd5;
    localparam logic [2:0] S_WB   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;
endpackage

// File: rtl/arm7_reglist_scan.sv
// Finds the lowest pending register in a transfer mask and counts the set bits.
module arm7_reglist_scan (
    input  logic [15:0] mask,
    output logic [3:0]  low_idx,
    output logic        any_set,
    output logic [4:0]  pop_cnt
);
    always_comb begin
        low_idx = '0;
        pop_cnt = '0;
        for (int i = 15; i >= 0; i--) begin
            if (mask[i]) low_idx = 4'(i);
        end
        for (int i = 0; i < 16; i++) begin
            pop_cnt = pop_cnt + 5'(mask[i]);
        end
        any_set = |mask;
    end
endmodule

// File: rtl/arm7_ldm_stm_sequencer.sv
// LDM/STM sequencer: walks the register list lowest-first, moving one word per
// register between the register file and memory, then applies base writeback.
module arm7_ldm_stm_sequencer
    import arm7_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre_index,
    input  logic              up,
    input  logic              s_bit,
    input  logic              writeback,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_value,
    input  logic [15:0]       reg_list,
    output logic              busy,
    output logic              done,
    output logic              rf_read_en,
    output logic [3:0]        rf_read_reg,
    input  logic [DATA_W-1:0] rf_read_value,
    output logic              rf_write_en,
    output logic [3:0]        rf_write_reg,
    output logic [DATA_W-1:0] rf_write_value,
    output logic              rf_write_restore_from_SPSR,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);
    logic [2:0]        state_q, state_d;
    logic              is_load_q, is_load_d, pre_q, pre_d, up_q, up_d;
    logic              s_bit_q, s_bit_d, wb_q, wb_d;
    logic [3:0]        base_reg_q, base_reg_d;
    logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, wbval_q, wbval_d;
    logic [15:0]       list_q, list_d, rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [3:0]        cur_idx;
    logic              any_left;
    logic [4:0]        pop_cnt;
    logic [ADDR_W-1:0] span;
    logic [15:0]       rem_next;
    logic [2:0]        after_xfer;
    logic              do_wb;

    arm7_reglist_scan u_scan (
        .mask    (rem_q),
        .low_idx (cur_idx),
        .any_set (any_left),
        .pop_cnt (pop_cnt)
    );

    // Only meaningful in CALC, where rem_q still equals the full list.
    assign span     = ADDR_W'(pop_cnt) * ADDR_W'(WORD_BYTES);
    assign rem_next = rem_q & ~(16'd1 << cur_idx);
    // A load that includes the base register keeps the loaded value.
    assign do_wb    = wb_q & ~(is_load_q & list_q[base_reg_q]);

    always_comb begin
        after_xfer = is_load_q ? S_MEM : S_RD;
        if (rem_next == 16'd0) after_xfer = do_wb ? S_WB : S_DONE;
    end

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        pre_d      = pre_q;
        up_d       = up_q;
        s_bit_d    = s_bit_q;
        wb_d       = wb_q;
        base_reg_d = base_reg_q;
        base_d     = base_q;
        list_d     = list_q;
        rem_d      = rem_q;
        addr_d     = addr_q;
        wbval_d    = wbval_q;
        data_d     = data_q;
        case (state_q)
            S_IDLE: if (start) begin
                is_load_d  = is_load;
                pre_d      = pre_index;
                up_d       = up;
                s_bit_d    = s_bit;
                wb_d       = writeback;
                base_reg_d = base_reg;
                base_d     = base_value;
                list_d     = reg_list;
                rem_d      = reg_list;
                state_d    = S_CALC;
            end
            S_CALC: begin
                if (up_q) addr_d = pre_q ? base_q + ADDR_W'(WORD_BYTES) : base_q;
                else      addr_d = pre_q ? base_q - span : base_q - span + ADDR_W'(WORD_BYTES);
                wbval_d = up_q ? base_q + span : base_q - span;
                if (!any_left)     state_d = S_DONE;
                else if (is_load_q) state_d = S_MEM;
                else               state_d = S_RD;
            end
            S_RD:  state_d = S_RDW;
            S_RDW: begin
                data_d  = rf_read_value;
                state_d = S_MEM;
            end
            S_MEM: if (mem_ack) begin
                if (is_load_q) begin
                    data_d  = mem_rdata;
                    state_d = S_WR;
                end else begin
                    rem_d   = rem_next;
                    addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                    state_d = after_xfer;
                end
            end
            S_WR: begin
                rem_d   = rem_next;
                addr_d  = addr_q + ADDR_W'(WORD_BYTES);
                state_d = after_xfer;
            end
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            is_load_q  <= 1'b0;
            pre_q      <= 1'b0;
            up_q       <= 1'b0;
            s_bit_q    <= 1'b0;
            wb_q       <= 1'b0;
            base_reg_q <= '0;
            base_q     <= '0;
            list_q     <= '0;
            rem_q      <= '0;
            addr_q     <= '0;
            wbval_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            pre_q      <= pre_d;
            up_q       <= up_d;
            s_bit_q    <= s_bit_d;
            wb_q       <= wb_d;
            base_reg_q <= base_reg_d;
            base_q     <= base_d;
            list_q     <= list_d;
            rem_q      <= rem_d;
            addr_q     <= addr_d;
            wbval_q    <= wbval_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        rf_read_en  = (state_q == S_RD);
        rf_read_reg = (state_q == S_RD) ? cur_idx : 4'd0;
        rf_write_en = (state_q == S_WR) || (state_q == S_WB);
        rf_write_reg   = 4'd0;
        rf_write_value = '0;
        if (state_q == S_WR) begin
            rf_write_reg   = cur_idx;
            rf_write_value = data_q;
        end else if (state_q == S_WB) begin
            rf_write_reg   = base_reg_q;
            rf_write_value = DATA_W'(wbval_q);
        end
        rf_write_restore_from_SPSR = (state_q == S_WR) & is_load_q & s_bit_q & (cur_idx == REG_PC);
        mem_req   = (state_q == S_MEM);
        mem_we    = (state_q == S_MEM) & ~is_load_q;
        mem_addr  = (state_q == S_MEM) ? addr_q : '0;
        mem_wdata = ((state_q == S_MEM) & ~is_load_q) ? data_q : '0;
    end
endmodule

// File: tb/tb_arm7_ldm_stm_sequencer.sv
// Directed bench: acts as register file and memory, predicts every transfer from the ISA rules.
module tb_arm7_ldm_stm_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 0, is_load = 0, pre_index = 0, up = 0, s_bit = 0, writeback = 0;
    logic [3:0]  base_reg = 0;
    logic [31:0] base_value = 0;
    logic [15:0] reg_list = 0;
    logic        busy, done, rf_read_en, rf_write_en, rf_write_restore_from_SPSR;
    logic [3:0]  rf_read_reg, rf_write_reg;
    logic [31:0] rf_read_value = 0, rf_write_value, mem_addr, mem_wdata, mem_rdata = 0;
    logic        mem_req, mem_we, mem_ack = 0;

    arm7_ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .pre_index(pre_index),
        .up(up), .s_bit(s_bit), .writeback(writeback), .base_reg(base_reg),
        .base_value(base_value), .reg_list(reg_list), .busy(busy), .done(done),
        .rf_read_en(rf_read_en), .rf_read_reg(rf_read_reg), .rf_read_value(rf_read_value),
        .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg), .rf_write_value(rf_write_value),
        .rf_write_restore_from_SPSR(rf_write_restore_from_SPSR), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] a; logic we; logic [31:0] d; } mexp_t;
    typedef struct { logic [3:0] r; logic [31:0] v; logic rs; } wexp_t;

    mexp_t       q_mem[$];
    wexp_t       q_wr[$];
    logic [3:0]  q_rd[$];
    logic [31:0] rf_m [16];
    logic [31:0] mem_m [logic [31:0]];

    int errors = 0, checks = 0;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, act_cnt = 0, restore_cnt = 0;
    int ack_delay = 0, req_cyc = 0, last_req_cycles = 0;
    bit in_req = 0, rd_pend = 0;
    logic [3:0]  rd_reg = 0;
    logic [31:0] cur_addr = 0, cur_wdata = 0;
    logic        cur_we = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : 32'h0;
    endfunction

    // Model: derive the full transfer list from the P/U/S/W/L rules.
    task automatic plan(input logic ld, input logic p, input logic u, input logic s, input logic w,
                        input logic [3:0] br, input logic [31:0] base, input logic [15:0] list);
        int n;
        logic [31:0] a, wbv;
        n = $countones(list);
        if (u) a = p ? base + 32'd4 : base;
        else   a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
        wbv = u ? base + 32'(4 * n) : base - 32'(4 * n);
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                if (ld) begin
                    q_mem.push_back('{a, 1'b0, 32'h0});
                    q_wr.push_back('{4'(i), mem_rd(a), s && (i == 15)});
                end else begin
                    q_rd.push_back(4'(i));
                    q_mem.push_back('{a, 1'b1, rf_m[i]});
                end
                a = a + 32'd4;
            end
        end
        if (n > 0 && w && !(ld && list[br])) q_wr.push_back('{br, wbv, 1'b0});
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Single compare/respond process: checks every cycle, then plays RF and memory.
    always @(negedge clk) begin
        if (rst) begin
            in_req = 0; rd_pend = 0; mem_ack = 0;
        end else begin
            if (rf_read_en || rf_write_en || mem_req) act_cnt++;
            if (rf_read_en && rf_write_en) check("rd_wr_exclusive", 32'd1, 32'd0);
            if (!busy && (rf_read_en || rf_write_en || mem_req || done)) check("busy_cover", 32'(busy), 32'd1);
            if (!rf_write_en) check("restore_idle", 32'(rf_write_restore_from_SPSR), 32'd0);
            if (rf_read_en) begin
                if (q_rd.size() == 0) check("rd_unexpected", 32'(rf_read_reg), 32'hFFFF_FFFF);
                else check("rd_reg", 32'(rf_read_reg), 32'(q_rd.pop_front()));
            end
            if (rf_write_en) begin
                if (rf_write_restore_from_SPSR) restore_cnt++;
                if (q_wr.size() == 0) check("wr_unexpected", 32'(rf_write_reg), 32'hFFFF_FFFF);
                else begin
                    wexp_t e;
                    e = q_wr.pop_front();
                    check("wr_reg", 32'(rf_write_reg), 32'(e.r));
                    check("wr_value", rf_write_value, e.v);
                    check("wr_restore", 32'(rf_write_restore_from_SPSR), 32'(e.rs));
                end
                rf_m[rf_write_reg] = rf_write_value;
            end
            mem_ack = 0;
            if (mem_req) begin
                if (!in_req) begin
                    if (q_mem.size() == 0) check("mem_unexpected", mem_addr, 32'hFFFF_FFFF);
                    else begin
                        mexp_t e;
                        e = q_mem.pop_front();
                        check("mem_addr", mem_addr, e.a);
                        check("mem_we", 32'(mem_we), 32'(e.we));
                        if (e.we) check("mem_wdata", mem_wdata, e.d);
                    end
                    in_req = 1; req_cyc = 1;
                    cur_addr = mem_addr; cur_wdata = mem_wdata; cur_we = mem_we;
                end else begin
                    req_cyc++;
                    check("addr_stable", mem_addr, cur_addr);
                    check("wdata_stable", mem_wdata, cur_wdata);
                    check("we_stable", 32'(mem_we), 32'(cur_we));
                end
                if (req_cyc > ack_delay) begin
                    mem_ack = 1;
                    if (mem_we) mem_m[mem_addr] = mem_wdata;
                    else mem_rdata = mem_rd(mem_addr);
                    in_req = 0;
                    last_req_cycles = req_cyc;
                end
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (rd_pend) rf_read_value = rf_m[rd_reg];
            rd_pend = rf_read_en;
            rd_reg  = rf_read_reg;
        end
    end

    task automatic drive(input logic ld, input logic p, input logic u, input logic s, input logic w,
                         input logic [3:0] br, input logic [31:0] base, input logic [15:0] list);
        is_load = ld; pre_index = p; up = u; s_bit = s; writeback = w;
        base_reg = br; base_value = base; reg_list = list;
    endtask

    task automatic run(input logic ld, input logic p, input logic u, input logic s, input logic w,
                       input logic [3:0] br, input logic [31:0] base, input logic [15:0] list,
                       input int delay);
        int d0;
        bit got;
        plan(ld, p, u, s, w, br, base, list);
        ack_delay = delay;
        d0 = done_cnt;
        @(negedge clk);
        drive(ld, p, u, s, w, br, base, list);
        start = 1; start_cyc = cyc;
        @(negedge clk);
        start = 0;
        got = 0;
        for (int k = 0; k < 300 && !got; k++) begin
            @(posedge clk);
            if (done_cnt != d0) got = 1;
        end
        check("done_seen", 32'(got), 32'd1);
        @(negedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_once", 32'(done_cnt - d0), 32'd1);
        check("model_drained", 32'(q_mem.size() + q_wr.size() + q_rd.size()), 32'd0);
    endtask

    initial begin
        int a0, d0;
        for (int i = 0; i < 16; i++) rf_m[i] = 32'h100 + 32'(i);
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(|{busy, done, rf_read_en, rf_write_en, rf_write_reg, rf_read_reg,
              rf_write_value, rf_write_restore_from_SPSR, mem_req, mem_we, mem_addr, mem_wdata}), 32'd0);
        rst = 0;

        // STMIA R13!, {R0,R4}
        rf_m[0] = 32'h11; rf_m[4] = 32'hDEADBEEF; rf_m[13] = 32'h1000;
        run(0, 0, 1, 0, 1, 4'd13, 32'h1000, 16'h0011, 0);
        check("stm_word0", mem_rd(32'h1000), 32'h11);
        check("stm_word1", mem_rd(32'h1004), 32'hDEADBEEF);
        check("stm_wb", rf_m[13], 32'h1008);

        // LDMDB R13!, {R1-R3}
        mem_m[32'h1FF4] = 32'hA; mem_m[32'h1FF8] = 32'hB; mem_m[32'h1FFC] = 32'hC;
        run(1, 1, 0, 0, 1, 4'd13, 32'h2000, 16'h000E, 1);
        check("ldmdb_r1", rf_m[1], 32'hA);
        check("ldmdb_r2", rf_m[2], 32'hB);
        check("ldmdb_r3", rf_m[3], 32'hC);
        check("ldmdb_wb", rf_m[13], 32'h1FF4);

        // LDMIA R0, {R15}^
        rf_m[0] = 32'h3000; mem_m[32'h3000] = 32'h00003004; restore_cnt = 0;
        run(1, 0, 1, 1, 0, 4'd0, 32'h3000, 16'h8000, 0);
        check("ldm_pc", rf_m[15], 32'h00003004);
        check("ldm_pc_restore", 32'(restore_cnt), 32'd1);
        check("ldm_pc_base_kept", rf_m[0], 32'h3000);

        // Empty list with W=1; start re-pulsed during DONE must be ignored
        a0 = act_cnt; d0 = done_cnt;
        @(negedge clk);
        drive(0, 0, 1, 0, 1, 4'd13, 32'h5000, 16'h0000);
        start = 1; start_cyc = cyc;
        @(negedge clk); start = 0;
        @(negedge clk); start = 1;
        @(negedge clk); start = 0; #1;
        check("empty_latency", 32'(done_cyc - start_cyc), 32'd2);
        check("empty_done_once", 32'(done_cnt - d0), 32'd1);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("empty_no_traffic", 32'(act_cnt - a0), 32'd0);
        check("empty_stays_idle", 32'(busy), 32'd0);

        // STMIA R1, {R2} with a 3-cycle ack delay
        rf_m[2] = 32'h22222222;
        run(0, 0, 1, 0, 0, 4'd1, 32'h4000, 16'h0004, 3);
        check("slow_req_cycles", 32'(last_req_cycles), 32'd4);
        check("slow_word", mem_rd(32'h4000), 32'h22222222);

        // Same, but reset lands while waiting for ack
        plan(0, 0, 1, 0, 0, 4'd1, 32'h6000, 16'h0004);
        ack_delay = 1000;
        @(negedge clk);
        drive(0, 0, 1, 0, 0, 4'd1, 32'h6000, 16'h0004);
        start = 1;
        @(negedge clk); start = 0;
        for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
        check("req_before_reset", 32'(mem_req), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        check("midreset_outputs", 32'(|{busy, done, rf_read_en, rf_write_en, rf_write_reg, rf_read_reg,
              rf_write_value, rf_write_restore_from_SPSR, mem_req, mem_we, mem_addr, mem_wdata}), 32'd0);
        q_mem.delete(); q_wr.delete(); q_rd.delete();
        @(negedge clk); @(negedge clk);
        rst = 0;
        rf_m[3] = 32'h33330000;
        run(0, 0, 1, 0, 0, 4'd1, 32'h7000, 16'h0008, 0);
        check("post_reset_store", mem_rd(32'h7000), 32'h33330000);

        // LDMIA R5!, {R5,R6}: loaded base wins over writeback
        mem_m[32'h100] = 32'h55AA; mem_m[32'h104] = 32'h66BB;
        run(1, 0, 1, 0, 1, 4'd5, 32'h100, 16'h0060, 0);
        check("ldm_base_loaded", rf_m[5], 32'h55AA);
        check("ldm_r6", rf_m[6], 32'h66BB);

        // STMDA R1!, {R0,R1}: stored base is the original value
        rf_m[0] = 32'hC0C0; rf_m[1] = 32'h10;
        run(0, 0, 0, 0, 1, 4'd1, 32'h10, 16'h0003, 2);
        check("stmda_r0", mem_rd(32'hC), 32'hC0C0);
        check("stmda_r1", mem_rd(32'h10), 32'h10);
        check("stmda_wb", rf_m[1], 32'h8);

        // LDMIB R2!, {R7} from 0xFFFFFFFC wraps to 0
        mem_m[32'h0] = 32'h77;
        run(1, 1, 1, 0, 1, 4'd2, 32'hFFFF_FFFC, 16'h0080, 0);
        check("wrap_load", rf_m[7], 32'h77);
        check("wrap_wb", rf_m[2], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/arm7_ldm_stm_sequencer.md
Name: arm7_ldm_stm_sequencer

Overview:
Initiator-side companion to the ARM7 register file: sequences LDM/STM block transfers. It drives the register file read and write ports (including restore-from-SPSR) and a word-wide memory request/ack port. The execute stage pulses start with decoded instruction fields and stalls on busy until done.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, register/memory data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request; ignored while busy
is_load  in  1  L bit: 1=LDM, 0=STM
pre_index  in  1  P bit
up  in  1  U bit
s_bit  in  1  S bit (^ suffix)
writeback  in  1  W bit
base_reg  in  4  Rn index
base_value  in  ADDR_W  Rn value at start
reg_list  in  16  register list, bit i = Ri
busy  out  1  high from cycle after start until done cycle inclusive
done  out  1  one-cycle completion pulse
rf_read_en  out  1  register file read strobe
rf_read_reg  out  4  register to read
rf_read_value  in  DATA_W  read data, valid the cycle after rf_read_en
rf_write_en  out  1  register file write strobe
rf_write_reg  out  4  register to write
rf_write_value  out  DATA_W  write data
rf_write_restore_from_SPSR  out  1  CPSR<-SPSR with this write
mem_req  out  1  memory request
mem_we  out  1  1=store
mem_addr  out  ADDR_W  word address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data, valid with mem_ack
mem_ack  in  1  completes current request

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, in-flight request dropped, captured fields cleared.
- start accepted only in IDLE; fields and base_value latched on acceptance.
- States: IDLE -> CALC -> (STM: RD -> RDW -> MEM) / (LDM: MEM -> WR) per register -> WB -> DONE -> IDLE.
- CALC (1 cycle): n = popcount(reg_list). Start address: U=1,P=0: base; U=1,P=1: base+4; U=0,P=0: base-4n+4; U=0,P=1: base-4n. Writeback value: U=1: base+4n; U=0: base-4n. Arithmetic modulo 2^32, wraps silently.
- Registers transferred lowest index first at ascending addresses, +4 per transfer.
- STM: RD asserts rf_read_en one cycle; RDW captures rf_read_value; MEM drives mem_req=1, mem_we=1, addr, wdata.
- LDM: MEM drives mem_req=1, mem_we=0; on ack capture mem_rdata; WR asserts rf_write_en one cycle with captured value.
- Handshake: mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack sampled high at a rising edge; mem_req deasserts the next cycle. Ack in the first req cycle is legal. mem_ack while mem_req=0 ignored.
- rf_write_restore_from_SPSR=1 only on the R15 write when is_load & s_bit & reg_list[15]; else 0.
- WB: if writeback and not (is_load & reg_list[base_reg]), one-cycle rf write base_reg <- writeback value; otherwise skipped (0 cycles). For STM, the stored base is the original value because writeback follows all stores.
- Empty reg_list: CALC -> DONE directly, no memory or register traffic, no writeback.
- DONE: done=1 for one cycle, busy=1 in that cycle; start in the DONE cycle is ignored.
- rf_read_en and rf_write_en never asserted in the same cycle.

Decomposition:
- arm7_pkg: state encoding enum, REG_PC=4'd15, WORD_BYTES=4.
- Sub-module arm7_reglist_scan (combinational): input remaining 16-bit mask; outputs lowest set index, any_set, popcount. The sequencer clears each bit after its transfer.

Test Plan:
- STMIA! R13=0x1000, list {R0,R4}, R0=0x11, R4=0xDEADBEEF, immediate ack -> mem writes 0x1000=0x11, 0x1004=0xDEADBEEF; rf write R13=0x1008; done once.
- LDMDB! base R13=0x2000, list {R1,R2,R3}, memory returns 0xA,0xB,0xC -> reads 0x1FF4,0x1FF8,0x1FFC; R1=0xA, R2=0xB, R3=0xC; R13=0x1FF4.
- LDMIA R0, {R15}^, base 0x3000, data 0x00003004 -> single rf write R15=0x00003004 with restore_from_SPSR=1; no writeback.
- Empty list, W=1 -> done two cycles after start; mem_req, rf_write_en, rf_read_en never asserted.
- STMIA list {R2}, mem_ack delayed 3 cycles -> addr and wdata stable all 4 req cycles. Repeat with rst asserted mid-wait -> all outputs 0 immediately, busy 0, later start works.
- LDMIA! R5, {R5,R6}, base 0x100 -> R5 gets loaded word, no 0x108 writeback write.
